// File: rtl/fmac_issue_arbiter_if.sv
// Request, datapath and response bundle between the FMAC issue arbiter and its neighbours.
// The slave side is the arbiter; the master side is the requesters, datapath and consumer.
interface fmac_issue_arbiter_if #(
    parameter int PARM_W = 32
);
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [1:0]        req0_op_i;
    logic [2:0]        req0_rm_i;
    logic [PARM_W-1:0] req0_a_i;
    logic [PARM_W-1:0] req0_b_i;
    logic [PARM_W-1:0] req0_c_i;

    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [1:0]        req1_op_i;
    logic [2:0]        req1_rm_i;
    logic [PARM_W-1:0] req1_a_i;
    logic [PARM_W-1:0] req1_b_i;
    logic [PARM_W-1:0] req1_c_i;

    logic [PARM_W-1:0] dp_a_o;
    logic [PARM_W-1:0] dp_b_o;
    logic [PARM_W-1:0] dp_c_o;
    logic [2:0]        dp_rm_o;
    logic              dp_sub_sign_o;
    logic              dp_special_o;
    logic [3:0]        dp_stage_en_o;
    logic [PARM_W-1:0] dp_result_i;
    logic [4:0]        dp_flags_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_id_o;
    logic [PARM_W-1:0] rsp_result_o;
    logic [4:0]        rsp_flags_o;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_rm_i, req0_a_i, req0_b_i, req0_c_i,
        input  req1_valid_i, req1_op_i, req1_rm_i, req1_a_i, req1_b_i, req1_c_i,
        input  dp_result_i, dp_flags_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output dp_a_o, dp_b_o, dp_c_o, dp_rm_o, dp_sub_sign_o, dp_special_o, dp_stage_en_o,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_rm_i, req0_a_i, req0_b_i, req0_c_i,
        output req1_valid_i, req1_op_i, req1_rm_i, req1_a_i, req1_b_i, req1_c_i,
        output dp_result_i, dp_flags_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  dp_a_o, dp_b_o, dp_c_o, dp_rm_o, dp_sub_sign_o, dp_special_o, dp_stage_en_o,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o
    );
endinterface

// File: rtl/fmac_issue_arbiter.sv
// Round-robin issue arbiter and stage sequencer for the single-precision FMA datapath.
//
// state | meaning
// IDLE  | waiting for a request
// MUL   | multiplier / Wallace tree enabled
// ALIGN | pre-normalizer / aligner enabled
// ADD   | adder enabled
// NORM  | normalizer / rounder enabled, result captured on exit
// RESP  | response held until rsp_ready_i
module fmac_issue_arbiter #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_W    = PARM_EXP + PARM_MANT + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    fmac_issue_arbiter_if.slave  bus,
    output logic                 busy_o,
    output logic [15:0]          op_count_o
);
    localparam int SGN = PARM_W - 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_ALIGN, S_ADD, S_NORM, S_RESP} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic              id_q;
    logic [PARM_W-1:0] dp_a_q, dp_b_q, dp_c_q, rsp_result_q;
    logic [2:0]        dp_rm_q;
    logic              dp_sub_q, dp_special_q;
    logic [4:0]        rsp_flags_q;
    logic [15:0]       op_count_q;

    logic              window, accept, grant;
    logic [1:0]        sel_op;
    logic [2:0]        sel_rm;
    logic [PARM_W-1:0] sel_a, sel_b, sel_c;
    logic              sel_special, add_sign, prod_sign;
    logic [3:0]        stage_en;

    function automatic logic exp_ones(input logic [PARM_W-1:0] x);
        return &x[PARM_MANT +: PARM_EXP];
    endfunction

    function automatic logic is_zero(input logic [PARM_W-1:0] x);
        return x[PARM_W-2:0] == '0;
    endfunction

    // On a tie the requester that did not win last time is served.
    assign grant  = (bus.req0_valid_i && bus.req1_valid_i) ? ~last_grant_q : bus.req1_valid_i;
    assign window = (state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready_i);
    assign accept = window && !flush_i && (bus.req0_valid_i || bus.req1_valid_i);

    assign bus.req0_ready_o = accept && !grant;
    assign bus.req1_ready_o = accept && grant;

    assign sel_op = grant ? bus.req1_op_i : bus.req0_op_i;
    assign sel_rm = grant ? bus.req1_rm_i : bus.req0_rm_i;
    assign sel_a  = grant ? bus.req1_a_i  : bus.req0_a_i;
    assign sel_b  = grant ? bus.req1_b_i  : bus.req0_b_i;
    assign sel_c  = grant ? bus.req1_c_i  : bus.req0_c_i;

    assign prod_sign   = sel_b[SGN] ^ sel_c[SGN] ^ sel_op[1];
    assign add_sign    = sel_a[SGN] ^ sel_op[0];
    assign sel_special = exp_ones(sel_a) || exp_ones(sel_b) || exp_ones(sel_c) ||
                         is_zero(sel_b) || is_zero(sel_c);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = sel_special ? S_NORM : S_MUL;
            S_MUL:   state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    if (accept) state_d = sel_special ? S_NORM : S_MUL;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_comb begin
        stage_en = 4'b0000;
        case (state_q)
            S_MUL:   stage_en = 4'b0001;
            S_ALIGN: stage_en = 4'b0010;
            S_ADD:   stage_en = 4'b0100;
            S_NORM:  stage_en = 4'b1000;
            default: stage_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            dp_c_q       <= '0;
            dp_rm_q      <= '0;
            dp_sub_q     <= 1'b0;
            dp_special_q <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            op_count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant;
                id_q         <= grant;
                dp_a_q       <= {add_sign, sel_a[SGN-1:0]};
                dp_b_q       <= {sel_b[SGN] ^ sel_op[1], sel_b[SGN-1:0]};
                dp_c_q       <= sel_c;
                dp_rm_q      <= sel_rm;
                dp_sub_q     <= prod_sign ^ add_sign;
                dp_special_q <= sel_special;
            end
            if ((state_q == S_NORM) && !flush_i) begin
                rsp_result_q <= bus.dp_result_i;
                rsp_flags_q  <= bus.dp_flags_i;
            end
            if ((state_q == S_RESP) && bus.rsp_ready_i && !flush_i) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign bus.dp_a_o        = dp_a_q;
    assign bus.dp_b_o        = dp_b_q;
    assign bus.dp_c_o        = dp_c_q;
    assign bus.dp_rm_o       = dp_rm_q;
    assign bus.dp_sub_sign_o = dp_sub_q;
    assign bus.dp_special_o  = dp_special_q;
    assign bus.dp_stage_en_o = stage_en;
    assign bus.rsp_valid_o   = (state_q == S_RESP);
    assign bus.rsp_id_o      = id_q;
    assign bus.rsp_result_o  = rsp_result_q;
    assign bus.rsp_flags_o   = rsp_flags_q;
    assign busy_o            = (state_q != S_IDLE);
    assign op_count_o        = op_count_q;
endmodule

// File: tb/tb_fmac_issue_arbiter.sv
// Directed and random checks of fmac_issue_arbiter against a cycle-count reference model.
module tb_fmac_issue_arbiter;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    fmac_issue_arbiter_if ifc ();

    fmac_issue_arbiter dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .bus       (ifc),
        .busy_o    (busy),
        .op_count_o(op_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 working (m_k = cycles since accept), 2 response pending.
    int          m_phase, m_k;
    bit          m_last, m_special, m_sub, m_id;
    logic [31:0] m_a, m_b, m_c, m_res;
    logic [2:0]  m_rm;
    logic [4:0]  m_flg;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_last = 1'b1; m_special = 1'b0; m_sub = 1'b0; m_id = 1'b0;
        m_a = '0; m_b = '0; m_c = '0; m_res = '0; m_rm = '0; m_flg = '0; m_cnt = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 64'(ifc.rsp_valid_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_stage_en"}, 64'(ifc.dp_stage_en_o), 64'(0));
        chk({tag, "_dp_a"}, 64'(ifc.dp_a_o), 64'(0));
        chk({tag, "_dp_b"}, 64'(ifc.dp_b_o), 64'(0));
        chk({tag, "_dp_c"}, 64'(ifc.dp_c_o), 64'(0));
        chk({tag, "_dp_rm"}, 64'(ifc.dp_rm_o), 64'(0));
        chk({tag, "_dp_sub"}, 64'(ifc.dp_sub_sign_o), 64'(0));
        chk({tag, "_dp_special"}, 64'(ifc.dp_special_o), 64'(0));
        chk({tag, "_rsp_id"}, 64'(ifc.rsp_id_o), 64'(0));
        chk({tag, "_rsp_result"}, 64'(ifc.rsp_result_o), 64'(0));
        chk({tag, "_rsp_flags"}, 64'(ifc.rsp_flags_o), 64'(0));
        chk({tag, "_op_count"}, 64'(op_count), 64'(0));
        chk({tag, "_req0_ready"}, 64'(ifc.req0_ready_o), 64'(0));
    endtask

    // One clock: compare DUT to the model, take the edge, advance the model.
    task automatic tick();
        bit          v0, v1, win, acc, g;
        logic [3:0]  en_exp;
        logic [1:0]  op;
        logic [31:0] a, b, c;
        #1;
        v0  = ifc.req0_valid_i;
        v1  = ifc.req1_valid_i;
        win = (m_phase == 0) || (m_phase == 2 && ifc.rsp_ready_i);
        acc = win && !flush && (v0 || v1);
        g   = (v0 && v1) ? !m_last : v1;
        en_exp = 4'b0000;
        if (m_phase == 1) en_exp = 4'b0001 << (m_special ? 3 : m_k - 1);
        chk("req0_ready", 64'(ifc.req0_ready_o), 64'(acc && !g));
        chk("req1_ready", 64'(ifc.req1_ready_o), 64'(acc && g));
        chk("rsp_valid", 64'(ifc.rsp_valid_o), 64'(m_phase == 2));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("stage_en", 64'(ifc.dp_stage_en_o), 64'(en_exp));
        chk("dp_a", 64'(ifc.dp_a_o), 64'(m_a));
        chk("dp_b", 64'(ifc.dp_b_o), 64'(m_b));
        chk("dp_c", 64'(ifc.dp_c_o), 64'(m_c));
        chk("dp_rm", 64'(ifc.dp_rm_o), 64'(m_rm));
        chk("dp_sub", 64'(ifc.dp_sub_sign_o), 64'(m_sub));
        chk("dp_special", 64'(ifc.dp_special_o), 64'(m_special));
        chk("op_count", 64'(op_count), 64'(m_cnt));
        if (m_phase == 2) begin
            chk("rsp_id", 64'(ifc.rsp_id_o), 64'(m_id));
            chk("rsp_result", 64'(ifc.rsp_result_o), 64'(m_res));
            chk("rsp_flags", 64'(ifc.rsp_flags_o), 64'(m_flg));
        end
        if (en_exp[3]) begin
            m_res = ifc.dp_result_i;
            m_flg = ifc.dp_flags_i;
        end
        @(posedge clk);
        if (flush) begin
            m_phase = 0;
        end else begin
            if (m_phase == 2 && ifc.rsp_ready_i) begin
                m_cnt   = m_cnt + 16'd1;
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (en_exp[3]) m_phase = 2;
                else           m_k = m_k + 1;
            end
            if (acc) begin
                op   = g ? ifc.req1_op_i : ifc.req0_op_i;
                a    = g ? ifc.req1_a_i  : ifc.req0_a_i;
                b    = g ? ifc.req1_b_i  : ifc.req0_b_i;
                c    = g ? ifc.req1_c_i  : ifc.req0_c_i;
                m_rm = g ? ifc.req1_rm_i : ifc.req0_rm_i;
                m_a  = {a[31] ^ op[0], a[30:0]};
                m_b  = {b[31] ^ op[1], b[30:0]};
                m_c  = c;
                m_sub = (b[31] ^ c[31] ^ op[1]) ^ (a[31] ^ op[0]);
                m_special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (c[30:23] == 8'hFF) ||
                            (b[30:0] == 31'd0) || (c[30:0] == 31'd0);
                m_id    = g;
                m_last  = g;
                m_phase = 1;
                m_k     = 1;
            end
        end
        #1;
        ifc.dp_result_i = $urandom;
        ifc.dp_flags_i  = 5'($urandom);
    endtask

    task automatic run_until(input int goal, input int max_cycles);
        int n = 0;
        while (m_phase != goal && n < max_cycles) begin
            tick();
            n++;
        end
        if (m_phase != goal) begin
            n_fail++;
            $display("FAIL wait_phase observed=%0d expected=%0d", m_phase, goal);
        end
    endtask

    task automatic set_req(input bit sel, input bit v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [2:0] rm);
        if (sel) begin
            ifc.req1_valid_i = v; ifc.req1_op_i = op; ifc.req1_rm_i = rm;
            ifc.req1_a_i = a; ifc.req1_b_i = b; ifc.req1_c_i = c;
        end else begin
            ifc.req0_valid_i = v; ifc.req0_op_i = op; ifc.req0_rm_i = rm;
            ifc.req0_a_i = a; ifc.req0_b_i = b; ifc.req0_c_i = c;
        end
    endtask

    task automatic issue(input bit sel, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] rm);
        set_req(sel, 1'b1, op, a, b, c, rm);
        tick();
        ifc.req0_valid_i = 1'b0;
        ifc.req1_valid_i = 1'b0;
    endtask

    task automatic complete();
        run_until(2, 10);
        ifc.rsp_ready_i = 1'b1;
        tick();
        ifc.rsp_ready_i = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return {1'($urandom), 8'hFF, 23'($urandom)};
            1:       return {1'($urandom), 31'd0};
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] hold_res;
    logic [4:0]  hold_flg;
    logic [15:0] hold_cnt;
    logic [3:0]  rr_ids;
    int          n_hs, idle_seen;

    initial begin
        set_req(1'b0, 1'b0, 2'b00, '0, '0, '0, '0);
        set_req(1'b1, 1'b0, 2'b00, '0, '0, '0, '0);
        ifc.rsp_ready_i = 1'b0;
        ifc.dp_result_i = '0;
        ifc.dp_flags_i  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // fmadd from req0 while req1 is also valid: req0 must win the first tie
        set_req(1'b0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd0);
        set_req(1'b1, 1'b1, 2'b01, 32'h3F000000, 32'h3F000000, 32'h3F000000, 3'd1);
        tick();
        ifc.req0_valid_i = 1'b0;
        ifc.req1_valid_i = 1'b0;
        chk("fmadd_sub", 64'(ifc.dp_sub_sign_o), 64'(0));
        chk("fmadd_a", 64'(ifc.dp_a_o), 64'h3F800000);
        chk("fmadd_stage1", 64'(ifc.dp_stage_en_o), 64'b0001);
        tick(); chk("fmadd_stage2", 64'(ifc.dp_stage_en_o), 64'b0010);
        tick(); chk("fmadd_stage3", 64'(ifc.dp_stage_en_o), 64'b0100);
        tick(); chk("fmadd_stage4", 64'(ifc.dp_stage_en_o), 64'b1000);
        chk("fmadd_valid_early", 64'(ifc.rsp_valid_o), 64'(0));
        tick(); chk("fmadd_valid_c5", 64'(ifc.rsp_valid_o), 64'(1));
        chk("fmadd_id", 64'(ifc.rsp_id_o), 64'(0));
        ifc.rsp_ready_i = 1'b1;
        tick();
        ifc.rsp_ready_i = 1'b0;
        chk("fmadd_count", 64'(op_count), 64'(1));

        // effective subtraction
        issue(1'b0, 2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd2);
        chk("fmsub_sub", 64'(ifc.dp_sub_sign_o), 64'(1));
        chk("fmsub_a_sign", 64'(ifc.dp_a_o[31]), 64'(1));
        complete();
        issue(1'b0, 2'b11, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd4);
        chk("fnmadd_sub", 64'(ifc.dp_sub_sign_o), 64'(0));
        chk("fnmadd_a_sign", 64'(ifc.dp_a_o[31]), 64'(1));
        chk("fnmadd_b_sign", 64'(ifc.dp_b_o[31]), 64'(1));
        complete();

        // special bypass: zero B, then NaN A
        issue(1'b0, 2'b00, 32'h3F800000, 32'h00000000, 32'h40400000, 3'd3);
        chk("zero_special", 64'(ifc.dp_special_o), 64'(1));
        chk("zero_stage", 64'(ifc.dp_stage_en_o), 64'b1000);
        tick(); chk("zero_valid_c2", 64'(ifc.rsp_valid_o), 64'(1));
        ifc.rsp_ready_i = 1'b1; tick(); ifc.rsp_ready_i = 1'b0;
        issue(1'b0, 2'b00, 32'h7FC00000, 32'h40000000, 32'h40400000, 3'd0);
        chk("nan_special", 64'(ifc.dp_special_o), 64'(1));
        chk("nan_stage", 64'(ifc.dp_stage_en_o), 64'b1000);
        tick(); chk("nan_valid_c2", 64'(ifc.rsp_valid_o), 64'(1));
        ifc.rsp_ready_i = 1'b1; tick(); ifc.rsp_ready_i = 1'b0;

        // one op from req1 so the next tie goes to req0
        issue(1'b1, 2'b00, 32'h40800000, 32'h40A00000, 32'h40C00000, 3'd1);
        chk("req1_id_dp_c", 64'(ifc.dp_c_o), 64'h40C00000);
        complete();

        // fairness with both requesters always valid
        set_req(1'b0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd0);
        set_req(1'b1, 1'b1, 2'b10, 32'h40000000, 32'h40400000, 32'h40800000, 3'd0);
        ifc.rsp_ready_i = 1'b1;
        tick();
        n_hs = 0; idle_seen = 0; rr_ids = '0;
        for (int i = 0; i < 40 && n_hs < 4; i++) begin
            #1;
            if (ifc.rsp_valid_o && ifc.rsp_ready_i) begin
                rr_ids = {rr_ids[2:0], ifc.rsp_id_o};
                n_hs++;
            end
            if (!busy) idle_seen++;
            tick();
        end
        ifc.req0_valid_i = 1'b0;
        ifc.req1_valid_i = 1'b0;
        chk("rr_handshakes", 64'(n_hs), 64'(4));
        chk("rr_ids", 64'(rr_ids), 64'b0101);
        chk("rr_back_to_back", 64'(idle_seen), 64'(0));
        run_until(0, 20);
        ifc.rsp_ready_i = 1'b0;

        // backpressure
        issue(1'b0, 2'b00, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'd0);
        run_until(2, 10);
        hold_res = ifc.rsp_result_o;
        hold_flg = ifc.rsp_flags_o;
        hold_cnt = op_count;
        ifc.req0_valid_i = 1'b1;
        ifc.req1_valid_i = 1'b1;
        repeat (6) begin
            tick();
            chk("bp_result", 64'(ifc.rsp_result_o), 64'(hold_res));
            chk("bp_flags", 64'(ifc.rsp_flags_o), 64'(hold_flg));
            chk("bp_ready0", 64'(ifc.req0_ready_o), 64'(0));
            chk("bp_busy", 64'(busy), 64'(1));
        end
        ifc.req0_valid_i = 1'b0;
        ifc.req1_valid_i = 1'b0;
        ifc.rsp_ready_i  = 1'b1;
        tick();
        ifc.rsp_ready_i  = 1'b0;
        chk("bp_count", 64'(op_count), 64'(hold_cnt + 16'd1));

        // flush in ALIGN
        hold_cnt = op_count;
        issue(1'b0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd0);
        tick();
        chk("flush_in_align", 64'(ifc.dp_stage_en_o), 64'b0010);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_stage", 64'(ifc.dp_stage_en_o), 64'(0));
        repeat (6) tick();
        chk("flush_count", 64'(op_count), 64'(hold_cnt));

        // flush wins over a response handshake
        issue(1'b1, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd0);
        run_until(2, 10);
        ifc.rsp_ready_i = 1'b1;
        flush = 1'b1; tick(); flush = 1'b0;
        ifc.rsp_ready_i = 1'b0;
        chk("flush_hs_count", 64'(op_count), 64'(hold_cnt));
        chk("flush_hs_valid", 64'(ifc.rsp_valid_o), 64'(0));

        // reset while in RESP
        issue(1'b0, 2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd5);
        run_until(2, 10);
        chk("pre_reset_valid", 64'(ifc.rsp_valid_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            set_req(1'b0, 1'($urandom), 2'($urandom), rnd_operand(), rnd_operand(), rnd_operand(), 3'($urandom));
            set_req(1'b1, 1'($urandom), 2'($urandom), rnd_operand(), rnd_operand(), rnd_operand(), 3'($urandom));
            ifc.rsp_ready_i = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;
        ifc.req0_valid_i = 1'b0;
        ifc.req1_valid_i = 1'b0;
        ifc.rsp_ready_i  = 1'b1;
        run_until(0, 20);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
